dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline core (stage-2 DMEM port) and the NIC.
//  The core has fixed priority; the NIC uses a req/gnt handshake.
//  A starvation counter forces a one-cycle core stall so that the NIC is served within MAX_WAIT cycles.

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the core (fixed priority) and the NIC (req/gnt), with a
// starvation stall bounding NIC wait. Optional perf counters under DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_mem_en,
    input  logic                  core_wr_en,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    input  logic                  nic_req,
    input  logic                  nic_wr_en,
    input  logic [ADDR_WIDTH-1:0] nic_addr,
    input  logic [DATA_WIDTH-1:0] nic_wdata,
    output logic                  nic_gnt,
    output logic [DATA_WIDTH-1:0] nic_rdata,
    output logic                  nic_rvalid,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]           perf_nic_grants,
    output logic [15:0]           perf_core_stalls,
`endif
    output logic                  dmem_en,
    output logic                  dmem_wr_en,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    typedef enum logic {S_NORMAL, S_STALL} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_NIC} owner_t;

    state_t     state, state_nxt;
    owner_t     rd_owner, rd_owner_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       core_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_NORMAL;
            wait_cnt <= 8'd0;
            rd_owner <= OWN_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        core_sel     = 1'b0;
        nic_gnt      = 1'b0;
        state_nxt    = S_NORMAL;
        wait_cnt_nxt = 8'd0;
        rd_owner_nxt = OWN_NONE;
        dmem_en      = 1'b0;
        dmem_wr_en   = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;

        if (state == S_STALL) begin
            // core is frozen this cycle and re-presents its request next cycle
            nic_gnt = nic_req;
        end else begin
            core_sel = core_mem_en;
            nic_gnt  = nic_req && !core_mem_en;
            if (nic_req && !nic_gnt) begin
                wait_cnt_nxt = wait_cnt + 8'd1;
                if (wait_cnt == 8'(MAX_WAIT - 1))
                    state_nxt = S_STALL;
            end
        end

        if (core_sel) begin
            dmem_en      = 1'b1;
            dmem_wr_en   = core_wr_en;
            dmem_addr    = core_addr;
            dmem_wdata   = core_wdata;
            rd_owner_nxt = core_wr_en ? OWN_NONE : OWN_CORE;
        end else if (nic_gnt) begin
            dmem_en      = 1'b1;
            dmem_wr_en   = nic_wr_en;
            dmem_addr    = nic_addr;
            dmem_wdata   = nic_wdata;
            rd_owner_nxt = nic_wr_en ? OWN_NONE : OWN_NIC;
        end
    end

    assign core_stall  = (state == S_STALL);
    assign core_rvalid = (rd_owner == OWN_CORE);
    assign nic_rvalid  = (rd_owner == OWN_NIC);
    assign core_rdata  = dmem_rdata;
    assign nic_rdata   = dmem_rdata;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_nic_grants  <= 16'd0;
            perf_core_stalls <= 16'd0;
        end else begin
            if (nic_gnt && perf_nic_grants != 16'hFFFF)
                perf_nic_grants <= perf_nic_grants + 16'd1;
            if (core_stall && perf_core_stalls != 16'hFFFF)
                perf_core_stalls <= perf_core_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inline checks on combinational arbitration plus a
// scoreboard queue of expected read returns popped by an independent monitor.
module tb_dmem_arbiter;
    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_mem_en, core_wr_en, nic_req, nic_wr_en;
    logic [AW-1:0] core_addr, nic_addr;
    logic [DW-1:0] core_wdata, nic_wdata;
    logic          core_stall, core_rvalid, nic_gnt, nic_rvalid;
    logic [DW-1:0] core_rdata, nic_rdata;
    logic          dmem_en, dmem_wr_en;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   perf_nic_grants, perf_core_stalls;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_nic;
        logic [DW-1:0] data;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_mem_en(core_mem_en), .core_wr_en(core_wr_en), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
        .core_rvalid(core_rvalid),
        .nic_req(nic_req), .nic_wr_en(nic_wr_en), .nic_addr(nic_addr), .nic_wdata(nic_wdata),
        .nic_gnt(nic_gnt), .nic_rdata(nic_rdata), .nic_rvalid(nic_rvalid),
`ifdef DMEM_ARB_PERF_EN
        .perf_nic_grants(perf_nic_grants), .perf_core_stalls(perf_core_stalls),
`endif
        .dmem_en(dmem_en), .dmem_wr_en(dmem_wr_en), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // DMEM macro model: synchronous write, one-cycle read
    logic [DW-1:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 64'hAA;
        dmem_rdata = '0;
    end
    always @(posedge clk) begin
        if (dmem_en) begin
            if (dmem_wr_en) mem[dmem_addr[7:0]] <= dmem_wdata;
            else            dmem_rdata <= mem[dmem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic core_drv(input logic en, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        core_mem_en = en; core_wr_en = wr; core_addr = a; core_wdata = d;
    endtask

    task automatic nic_drv(input logic rq, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        nic_req = rq; nic_wr_en = wr; nic_addr = a; nic_wdata = d;
    endtask

    task automatic push_rd(input bit is_nic, input logic [DW-1:0] d);
        rd_exp_t e;
        e.is_nic = is_nic;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    // Monitor: registered outputs sampled mid low-phase, after stimulus settles
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (core_rvalid || nic_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: core_rvalid=%0b nic_rvalid=%0b at %0t",
                             core_rvalid, nic_rvalid, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_owner", {62'd0, core_rvalid, nic_rvalid},
                        e.is_nic ? 64'd1 : 64'd2);
                    chk("rdata", e.is_nic ? nic_rdata : core_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        core_drv(0, 0, '0, '0);
        nic_drv(0, 0, '0, '0);

        // reset held for two cycles
        cyc(); cyc(); #1;
        chk("rst_core_stall", {63'd0, core_stall}, 64'd0);
        chk("rst_nic_gnt", {63'd0, nic_gnt}, 64'd0);
        chk("rst_rvalid", {62'd0, core_rvalid, nic_rvalid}, 64'd0);
        chk("rst_dmem_en", {63'd0, dmem_en}, 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            chk("idle_outs", {60'd0, dmem_en, core_stall, nic_gnt, dmem_wr_en}, 64'd0);
        end

        // core read of 0x10
        cyc(); core_drv(1, 0, 32'h10, '0); #1;
        chk("core_rd_en", {63'd0, dmem_en}, 64'd1);
        chk("core_rd_addr", {32'd0, dmem_addr}, 64'h10);
        push_rd(0, 64'hAA);
        cyc(); core_drv(0, 0, '0, '0);
        cyc();

        // contention: core write 0x30 wins, NIC read 0x10 granted next cycle
        cyc(); core_drv(1, 1, 32'h30, 64'h55); nic_drv(1, 0, 32'h10, '0); #1;
        chk("cont_gnt0", {63'd0, nic_gnt}, 64'd0);
        chk("cont_core_addr", {32'd0, dmem_addr}, 64'h30);
        cyc(); core_drv(0, 0, '0, '0); #1;
        chk("cont_gnt1", {63'd0, nic_gnt}, 64'd1);
        chk("cont_nic_addr", {32'd0, dmem_addr}, 64'h10);
        chk("cont_wait1", {56'd0, dut.wait_cnt}, 64'd1);
        push_rd(1, 64'hAA);
        cyc(); nic_drv(0, 0, '0, '0); #1;
        chk("cont_wait0", {56'd0, dut.wait_cnt}, 64'd0);

        // starvation: core reads 0x10 continuously, NIC reads 0x30 (holds 0x55)
        cyc(); core_drv(1, 0, 32'h10, '0); nic_drv(1, 0, 32'h30, '0);
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("starve_nostall", {62'd0, core_stall, nic_gnt}, 64'd0);
            push_rd(0, 64'hAA);
            cyc();
        end
        #1;
        chk("starve_stall_gnt", {62'd0, core_stall, nic_gnt}, 64'd3);
        chk("starve_nic_addr", {32'd0, dmem_addr}, 64'h30);
        push_rd(1, 64'h55);
        cyc(); nic_drv(0, 0, '0, '0); #1;
        chk("starve_reissue", {62'd0, core_stall, dmem_en}, 64'd1);
        chk("starve_core_addr", {32'd0, dmem_addr}, 64'h10);
        push_rd(0, 64'hAA);
        cyc(); core_drv(0, 0, '0, '0);
        cyc();

        // NIC write then read of 0x20
        cyc(); nic_drv(1, 1, 32'h20, 64'h1234); #1;
        chk("nic_wr_gnt", {62'd0, nic_gnt, dmem_wr_en}, 64'd3);
        cyc(); nic_drv(1, 0, 32'h20, '0); #1;
        chk("nic_rd_gnt", {62'd0, nic_gnt, dmem_wr_en}, 64'd2);
        push_rd(1, 64'h1234);
        cyc(); nic_drv(0, 0, '0, '0);

        // core read-after-write back-to-back
        cyc(); core_drv(1, 1, 32'h40, 64'hBEEF);
        cyc(); core_drv(1, 0, 32'h40, '0);
        push_rd(0, 64'hBEEF);
        cyc(); core_drv(0, 0, '0, '0);
        cyc();

        // NIC drops its request during the stall cycle: idle cycle, core resumes after
        cyc(); core_drv(1, 0, 32'h10, '0); nic_drv(1, 0, 32'h30, '0);
        for (int t = 0; t < 4; t++) begin
            push_rd(0, 64'hAA);
            cyc();
        end
        nic_drv(0, 0, '0, '0); #1;
        chk("viol_stall_idle", {61'd0, core_stall, dmem_en, nic_gnt}, 64'd4);
        cyc(); #1;
        chk("viol_resume", {62'd0, core_stall, dmem_en}, 64'd1);
        push_rd(0, 64'hAA);
        cyc(); core_drv(0, 0, '0, '0);
        cyc(); #1;

`ifdef DMEM_ARB_PERF_EN
        chk("perf_grants", {48'd0, perf_nic_grants}, 64'd4);
        chk("perf_stalls", {48'd0, perf_core_stalls}, 64'd2);
`endif

        // reset mid-read: rvalid must never appear
        cyc(); core_drv(1, 0, 32'h10, '0);
        @(posedge clk); #1; rst = 1'b0;
        cyc(); core_drv(0, 0, '0, '0); #1;
        chk("rst_mid_rvalid", {62'd0, core_rvalid, nic_rvalid}, 64'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("rst_perf", {32'd0, perf_nic_grants, perf_core_stalls}, 64'd0);
`endif
        cyc(); rst = 1'b1; #1;
        chk("post_rst_rvalid", {62'd0, core_rvalid, nic_rvalid}, 64'd0);
        cyc(); cyc(); #3;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
